// File: rtl/ram_arbiter_pkg.sv
// Shared widths, response-state encodings and master ids for the data-RAM arbiter.
// Consumed by ram_arbiter and ram_arb_pick.
package ram_arbiter_pkg;

  localparam int unsigned MemAddrBus = 32;
  localparam int unsigned InstBus    = 32;

  typedef enum logic [1:0] {
    RspIdle = 2'd0,
    RspRd   = 2'd1,
    RspErr  = 2'd2
  } rsp_state_e;

  localparam logic ArbM0 = 1'b0;
  localparam logic ArbM1 = 1'b1;

  // Width of a counter that must be able to hold max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational grant selection for the two-master RAM arbiter.
// prio_m1_i lets master 1 win a tie (starvation or round-robin turn).
module ram_arb_pick
  import ram_arbiter_pkg::*;
(
  input  logic       e0_i,
  input  logic       e1_i,
  input  logic       prio_m1_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (e1_i && (!e0_i || prio_m1_i)) begin
      gnt_o[ArbM1] = 1'b1;
    end else if (e0_i) begin
      gnt_o[ArbM0] = 1'b1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-master arbiter and sequencer in front of the single-port data RAM.
// Define RAM_ARB_RR_EN for round-robin; otherwise fixed priority with starvation escape.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned AW         = MemAddrBus,
  parameter int unsigned DW         = InstBus,
  parameter int unsigned MW         = DW / 8,
  parameter int unsigned DP         = 4096,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hold_i,

  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [MW-1:0] m0_wem,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_err,

  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic [MW-1:0] m1_wem,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_err,

  output logic          ram_cs,
  output logic          ram_we,
  output logic [MW-1:0] ram_wem,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  logic          e0, e1, prio_m1;
  logic [1:0]    gnt;
  logic          any_gnt, win_id;
  logic          sel_we;
  logic [MW-1:0] sel_wem;
  logic [AW-1:0] sel_addr, word_addr;
  logic [DW-1:0] sel_wdata;
  logic          in_range;

  rsp_state_e    rsp_d, rsp_q;
  logic          owner_d, owner_q;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_data;

  assign e0 = m0_req & ~hold_i;
  assign e1 = m1_req;

  ram_arb_pick u_pick (
    .e0_i      (e0),
    .e1_i      (e1),
    .prio_m1_i (prio_m1),
    .gnt_o     (gnt)
  );

  assign m0_gnt  = gnt[ArbM0];
  assign m1_gnt  = gnt[ArbM1];
  assign any_gnt = |gnt;
  assign win_id  = gnt[ArbM1] ? ArbM1 : ArbM0;

`ifdef RAM_ARB_RR_EN
  logic last_d, last_q;

  // Reset to m1 so m0 takes the very first tie.
  assign last_d  = any_gnt ? win_id : last_q;
  assign prio_m1 = (last_q == ArbM0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= ArbM1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  localparam int unsigned ScW = cnt_width(STARVE_MAX);
  localparam logic [ScW-1:0] StarveMax = ScW'(STARVE_MAX);

  logic [ScW-1:0] starve_cnt_d, starve_cnt_q;

  assign prio_m1 = (starve_cnt_q == StarveMax);

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!m1_req || gnt[ArbM1]) begin
      starve_cnt_d = '0;
    end else if (e1 && (starve_cnt_q != StarveMax)) begin
      starve_cnt_d = starve_cnt_q + ScW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`endif

  // Winner's request fields; all zero when nobody is granted.
  always_comb begin
    sel_we    = 1'b0;
    sel_wem   = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (gnt[ArbM1]) begin
      sel_we    = m1_we;
      sel_wem   = m1_wem;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
    end else if (gnt[ArbM0]) begin
      sel_we    = m0_we;
      sel_wem   = m0_wem;
      sel_addr  = m0_addr;
      sel_wdata = m0_wdata;
    end
  end

  assign word_addr = sel_addr >> 2;
  assign in_range  = (word_addr < AW'(DP));

  assign ram_cs   = any_gnt & in_range;
  assign ram_we   = sel_we;
  assign ram_wem  = sel_wem;
  assign ram_addr = sel_addr;
  assign ram_din  = sel_wdata;

  // Response tracking is re-evaluated every cycle, giving one access per cycle.
  always_comb begin
    rsp_d   = RspIdle;
    owner_d = owner_q;
    if (any_gnt) begin
      owner_d = win_id;
      if (!in_range) begin
        rsp_d = RspErr;
      end else if (!sel_we) begin
        rsp_d = RspRd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q   <= RspIdle;
      owner_q <= ArbM0;
    end else begin
      rsp_q   <= rsp_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_data  = '0;
    unique case (rsp_q)
      RspRd: begin
        rsp_valid = 1'b1;
        rsp_data  = ram_dout;
      end
      RspErr: begin
        rsp_valid = 1'b1;
        rsp_err   = 1'b1;
      end
      default: ;
    endcase
  end

  assign m0_rvalid = rsp_valid & (owner_q == ArbM0);
  assign m0_err    = rsp_err   & (owner_q == ArbM0);
  assign m0_rdata  = (owner_q == ArbM0) ? rsp_data : '0;
  assign m1_rvalid = rsp_valid & (owner_q == ArbM1);
  assign m1_err    = rsp_err   & (owner_q == ArbM1);
  assign m1_rdata  = (owner_q == ArbM1) ? rsp_data : '0;

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-master arbiter and sequencer in front of the core's single-port data RAM wrapper.
- Master 0 is the core load/store path, which is subject to pipeline hold. Master 1 is the debug/loader port.
- The block muxes one access per cycle onto the RAM's cs/we/wem/addr/din pins and returns synchronous read data to the owning master one cycle later.
- It also suppresses out-of-range accesses and flags them with an error response.

Parameters:
- AW, 32, address width in bits (byte address).
- DW, 32, data width in bits.
- MW, 4, number of byte-write-enable lanes (DW/8).
- DP, 4096, RAM depth in words; legal byte addresses are 0 .. DP*4-1.
- STARVE_MAX, 4, consecutive denied cycles after which master 1 is forced to win.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- hold_i  in  1  pipeline hold; while 1, master 0 is never granted.
- m0_req  in  1  master 0 access request.
- m0_we  in  1  master 0 write (1) / read (0).
- m0_addr  in  AW  master 0 byte address.
- m0_wdata  in  DW  master 0 write data.
- m0_wem  in  MW  master 0 byte write mask.
- m0_gnt  out  1  master 0 grant, same cycle as the request.
- m0_rvalid  out  1  master 0 read data valid.
- m0_rdata  out  DW  master 0 read data.
- m0_err  out  1  master 0 out-of-range response.
- m1_req, m1_we, m1_addr, m1_wdata, m1_wem, m1_gnt, m1_rvalid, m1_rdata, m1_err: same as master 0, for master 1.
- ram_cs  out  1  RAM chip select.
- ram_we  out  1  RAM write enable.
- ram_wem  out  MW  RAM byte mask.
- ram_addr  out  AW  RAM address.
- ram_din  out  DW  RAM write data.
- ram_dout  in  DW  RAM read data, valid the cycle after cs with we=0.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all gnt/rvalid/err outputs are 0, rdata is 0, ram_cs is 0, the starvation counter is 0, and the response register is idle.
- Eligibility: e0 = m0_req & ~hold_i; e1 = m1_req.
- Default arbitration (fixed priority):
  - Master 0 wins whenever e0 is set.
  - starve_cnt (clog2(STARVE_MAX+1) bits) increments on each cycle that e1 is set and m1 is not granted.
  - starve_cnt clears when m1 is granted or when m1_req is 0.
  - When starve_cnt == STARVE_MAX and e1 is set, m1 wins over m0. The counter saturates at STARVE_MAX.
- Grant is combinational: at most one of m0_gnt/m1_gnt is set per cycle. A request is consumed on the gnt cycle. A master that holds req after gnt is treated as a new request.
- RAM drive:
  - ram_cs = (any gnt) & in_range.
  - ram_we, ram_wem, ram_addr and ram_din are muxed from the winner. When idle they are 0.
  - in_range = (addr >> 2) < DP.
- Out-of-range access: gnt is still asserted but ram_cs is 0, so no RAM write occurs. The next cycle the winner sees rvalid=1, err=1, rdata=0 for both reads and writes.
- Response register (state machine RSP_IDLE / RSP_RD / RSP_ERR):
  - Granted in-range read -> RSP_RD with the owner latched.
  - Granted out-of-range access -> RSP_ERR.
  - Otherwise -> RSP_IDLE.
  - The next state is evaluated every cycle, so back-to-back grants are allowed and give 1 access/cycle throughput.
- Read latency: exactly 1 cycle from gnt. rvalid is a single-cycle pulse and goes only to the owner. In RSP_RD, rdata passes through combinationally from ram_dout. Writes produce no rvalid unless out of range.
- hold_i asserted in the cycle after an m0 read grant does not cancel that read's rvalid.
- Asynchronous reset mid-read: the pending rvalid is dropped; no response is emitted after reset release.
- Simultaneous requests: both masters requesting with equal eligibility resolves per the active policy. The loser sees gnt=0 and must hold its request stable.

Optional Feature:
- Macro: RAM_ARB_RR_EN.
- Defined: round-robin arbitration. A 1-bit last-winner register (reset = 1, so m0 wins the first tie) gives priority to the master not granted last. starve_cnt is removed. hold_i still masks m0.
- Undefined: fixed priority with the starvation counter, as in Behaviour.

Decomposition:
- Shared defines file:
  - MemAddrBus / InstBus width macros reused for AW/DW.
  - Response state encodings RSP_IDLE=2'd0, RSP_RD=2'd1, RSP_ERR=2'd2.
  - Master id constants ARB_M0=1'b0, ARB_M1=1'b1.
- One sub-module, ram_arb_pick: purely combinational grant selection (e0, e1, starve/last-winner in -> gnt vector). All registers stay in ram_arbiter.

Test Plan:
- Reset: assert rst_n=0 mid-read (m0 read granted at 0x10) -> no m0_rvalid after release; all outputs 0 during reset.
- Back-to-back reads: m0 reads 0x0, then 0x4 on consecutive cycles, with RAM preloaded 0xA5A5_0001/0xA5A5_0002 -> m0_rvalid on cycles +1 and +2 with those values; ram_cs high 2 cycles.
- Byte write: m1 writes wdata=0x1122_3344, wem=4'b0010 to 0x8 over 0xFFFF_FFFF, then reads -> 0xFFFF_33FF.
- Hold: m0_req and m1_req held, hold_i=1 -> m1_gnt=1, m0_gnt=0; drop hold_i -> m0 granted next cycle.
- Starvation (RR undefined): m0 and m1 both request continuously -> m0 granted 4 cycles, m1 granted on the 5th, then the counter clears. With RAM_ARB_RR_EN defined: grants alternate m0, m1, m0, ...
- Out of range: m0 writes to DP*4 -> ram_cs=0; next cycle m0_rvalid=1, m0_err=1, m0_rdata=0; RAM contents unchanged.
